// File: rtl/mac_acc.sv
// Signed multiply-accumulate back end: sums N_TAPS products, rounds half-up, rescales to O_WIDTH.
// Define MAC_ACC_SAT_EN to clip the result to O_WIDTH range and report clipping on sat_flag.
module mac_acc #(
    parameter int P_WIDTH   = 15,
    parameter int ACC_WIDTH = 20,
    parameter int O_WIDTH   = 8,
    parameter int SHIFT     = 7,
    parameter int N_TAPS    = 4
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               clear,
    input  logic               in_valid,
    input  logic [P_WIDTH-1:0] in_data,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [O_WIDTH-1:0] out_data,
    output logic               sat_flag
);

    localparam int CNT_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TAPS - 1);
    localparam logic signed [ACC_WIDTH:0] HALF = (ACC_WIDTH+1)'(1) << (SHIFT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [ACC_WIDTH-1:0]       r_acc;
    logic [CNT_W-1:0]           r_cnt;
    logic [O_WIDTH-1:0]         r_out;
    logic                       r_sat;
    logic                       w_take;
    logic                       w_last;
    logic signed [ACC_WIDTH:0]  w_sum;
    logic signed [ACC_WIDTH:0]  w_rnd;
    logic signed [ACC_WIDTH:0]  w_r;
    logic [O_WIDTH-1:0]         w_out;
    logic                       w_sat;

    assign in_ready  = (r_state != S_HOLD);
    assign out_valid = (r_state == S_HOLD);
    assign out_data  = r_out;
    assign sat_flag  = r_sat;

    assign w_take = in_valid && (r_state != S_HOLD);
    assign w_last = w_take && (r_cnt == LAST);

    // One extra bit of headroom so the rounding offset can never overflow.
    always_comb begin
        w_sum = {r_acc[ACC_WIDTH-1], r_acc}
              + {{(ACC_WIDTH+1-P_WIDTH){in_data[P_WIDTH-1]}}, in_data};
        w_rnd = w_sum + HALF;
        w_r   = w_rnd >>> SHIFT;
    end

`ifdef MAC_ACC_SAT_EN
    localparam logic signed [ACC_WIDTH:0] OMAX = (ACC_WIDTH+1)'((1 << (O_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH:0] OMIN = ~OMAX;

    always_comb begin
        w_out = w_r[O_WIDTH-1:0];
        w_sat = 1'b0;
        if (w_r > OMAX) begin
            w_out = OMAX[O_WIDTH-1:0];
            w_sat = 1'b1;
        end else if (w_r < OMIN) begin
            w_out = OMIN[O_WIDTH-1:0];
            w_sat = 1'b1;
        end
    end
`else
    logic w_unused;

    assign w_out    = w_r[O_WIDTH-1:0];
    assign w_sat    = 1'b0;
    assign w_unused = ^w_r[ACC_WIDTH:O_WIDTH];
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_ACC: begin
                if (w_last) begin
                    w_next = S_HOLD;
                end else if (w_take) begin
                    w_next = S_ACC;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (clear) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_out <= '0;
            r_sat <= 1'b0;
        end else if (clear) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_last) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_out <= w_out;
            r_sat <= w_sat;
        end else if (w_take) begin
            r_acc <= w_sum[ACC_WIDTH-1:0];
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mac_acc.sv
// Self-checking bench for mac_acc: arithmetic reference model checked every cycle plus
// directed vectors with hand-computed results (both MAC_ACC_SAT_EN settings supported).
module tb_mac_acc;

    localparam int P_WIDTH   = 15;
    localparam int ACC_WIDTH = 20;
    localparam int O_WIDTH   = 8;
    localparam int SHIFT     = 7;
    localparam int N_TAPS    = 4;

    logic               clk;
    logic               n_rst;
    logic               clear;
    logic               in_valid;
    logic [P_WIDTH-1:0] in_data;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;
    logic [O_WIDTH-1:0] out_data;
    logic               sat_flag;

    int checks   = 0;
    int failures = 0;

    mac_acc #(
        .P_WIDTH  (P_WIDTH),
        .ACC_WIDTH(ACC_WIDTH),
        .O_WIDTH  (O_WIDTH),
        .SHIFT    (SHIFT),
        .N_TAPS   (N_TAPS)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear    (clear),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .sat_flag (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: round half up, then clip or wrap to the output width.
    function automatic longint model_out(input longint sum, output bit sat);
        longint r;
        longint hi;
        longint lo;
        longint w;
        r   = (sum + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        hi  = (longint'(1) <<< (O_WIDTH - 1)) - 1;
        lo  = -(longint'(1) <<< (O_WIDTH - 1));
        sat = 1'b0;
`ifdef MAC_ACC_SAT_EN
        if (r > hi) begin
            sat = 1'b1;
            return hi;
        end
        if (r < lo) begin
            sat = 1'b1;
            return lo;
        end
        return r;
`else
        w = r % (hi + hi + 2);
        if (w > hi) w = w - (hi + hi + 2);
        if (w < lo) w = w + (hi + hi + 2);
        return w;
`endif
    endfunction

    bit     m_pending = 1'b0;
    int     m_beats   = 0;
    longint m_sum     = 0;
    longint m_exp     = 0;
    bit     m_sat     = 1'b0;

    always @(negedge clk) begin
        if (!n_rst) begin
            m_pending = 1'b0;
            m_beats   = 0;
            m_sum     = 0;
        end else begin
            check("mon_out_valid", longint'(out_valid), longint'(m_pending));
            check("mon_in_ready", longint'(in_ready), longint'(!m_pending));
            if (m_pending) begin
                check("mon_out_data", longint'($signed(out_data)), m_exp);
                check("mon_sat_flag", longint'(sat_flag), longint'(m_sat));
            end
            if (clear) begin
                m_pending = 1'b0;
                m_beats   = 0;
                m_sum     = 0;
            end else if (m_pending) begin
                if (out_ready) m_pending = 1'b0;
            end else if (in_valid) begin
                m_sum   = m_sum + longint'($signed(in_data));
                m_beats = m_beats + 1;
                if (m_beats == N_TAPS) begin
                    m_exp     = model_out(m_sum, m_sat);
                    m_pending = 1'b1;
                    m_sum     = 0;
                    m_beats   = 0;
                end
            end
        end
    end

    task automatic send(input int v);
        int k;
        k        = 0;
        in_valid = 1'b1;
        in_data  = P_WIDTH'(v);
        forever begin
            @(negedge clk);
            if (in_ready) break;
            k++;
            if (k > 50) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send4(input int v);
        for (int unsigned i = 0; i < 4; i++) send(v);
    endtask

    // Waits up to max_wait negedges for out_valid, checks literals, then lets the handshake complete.
    task automatic expect_result(input string name, input int max_wait,
                                 input longint exp_d, input longint exp_s);
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            k++;
            if (out_valid) break;
            if (k >= max_wait) break;
        end
        check({name, "_valid"}, longint'(out_valid), 1);
        check({name, "_data"}, longint'($signed(out_data)), exp_d);
        check({name, "_sat"}, longint'(sat_flag), exp_s);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_rst     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'($signed(out_data)), 0);
        check("rst_sat_flag", longint'(sat_flag), 0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", longint'(in_ready), 1);
        idle(1);

        // 1: basic sum, one-cycle latency and one-cycle valid
        send4(128);
        expect_result("t1", 1, 4, 0);
        @(negedge clk);
        check("t1_valid_drop", longint'(out_valid), 0);
        idle(1);

        // 2: negative and half-way rounding
        send4(-200);
        expect_result("t2_neg", 1, -6, 0);
        send(32); send(32); send(0); send(0);
        expect_result("t2_half", 1, 1, 0);

        // 3: overflow of output range
        send4(16383);
`ifdef MAC_ACC_SAT_EN
        expect_result("t3_pos", 1, 127, 1);
        send4(-16384);
        expect_result("t3_neg", 1, -128, 1);
`else
        expect_result("t3_pos", 1, 0, 0);
        send4(-16384);
        expect_result("t3_neg", 1, 0, 0);
`endif

        // 4: backpressure holds the result and blocks input
        out_ready = 1'b0;
        send4(128);
        in_valid = 1'b1;
        in_data  = P_WIDTH'(1000);
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_in_ready", longint'(in_ready), 0);
            check("t4_data_hold", longint'($signed(out_data)), 4);
            check("t4_valid_hold", longint'(out_valid), 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        idle(1);
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_released", longint'(out_valid), 0);
        idle(1);
        send4(-200);
        expect_result("t4_fresh", 1, -6, 0);

        // 5a: clear mid-accumulation, with a beat presented in the same cycle
        send(1000); send(1000);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = P_WIDTH'(1000);
        idle(1);
        clear    = 1'b0;
        in_valid = 1'b0;
        send4(128);
        expect_result("t5_clear", 1, 4, 0);

        // 5b: asynchronous reset mid-accumulation
        send(1000); send(1000);
        #2;
        n_rst = 1'b0;
        #1;
        check("t5_async_rst_data", longint'($signed(out_data)), 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        send4(128);
        expect_result("t5_reset", 1, 4, 0);

        // 5c: clear while a result is pending
        out_ready = 1'b0;
        send4(128);
        @(negedge clk);
        check("t5_hold_valid", longint'(out_valid), 1);
        @(posedge clk);
        #1;
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        @(negedge clk);
        check("t5_hold_clear", longint'(out_valid), 0);
        out_ready = 1'b1;
        idle(1);

        // 6: bubbles between accepted beats
        for (int unsigned i = 0; i < 4; i++) begin
            idle(int'($urandom_range(0, 3)));
            send(128);
        end
        expect_result("t6_bubbles", 1, 4, 0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
